// File: rtl/rs_encode_stream_out_ctrl.sv
// Output control for the RS encode path: emits a response header, then streams
// PARITY_LINES parity lines per block, round-robin over the encode units.
module rs_encode_stream_out_ctrl #(
   parameter int NUM_RS_UNITS   = -1,
   parameter int NUM_RS_UNITS_W = $clog2(NUM_RS_UNITS),
   parameter int DATA_W         = 256,
   parameter int PARITY_LINES   = 2,
   parameter int BLOCK_CNT_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_ctrl_out_ctrl_val,
   input  logic [BLOCK_CNT_W-1:0]         in_ctrl_out_ctrl_num_blocks,
   output logic                           out_ctrl_in_ctrl_rdy,
   input  logic [NUM_RS_UNITS-1:0]        rs_unit_out_ctrl_val,
   input  logic [NUM_RS_UNITS*DATA_W-1:0] rs_unit_out_ctrl_data,
   output logic [NUM_RS_UNITS-1:0]        out_ctrl_rs_unit_rdy,
   output logic                           stream_encoder_dst_hdr_val,
   output logic [BLOCK_CNT_W-1:0]         stream_encoder_dst_hdr_num_blocks,
   input  logic                           dst_stream_encoder_hdr_rdy,
   output logic                           stream_encoder_dst_data_val,
   output logic [DATA_W-1:0]              stream_encoder_dst_data,
   output logic                           stream_encoder_dst_data_last,
   input  logic                           dst_stream_encoder_data_rdy
);

   localparam int LINE_W = $clog2(PARITY_LINES + 1);

   typedef enum logic [1:0] {IDLE, HDR_OUT, DRAIN_BLOCK} state_t;

   state_t                    state;
   logic [BLOCK_CNT_W-1:0]    num_blocks;
   logic [BLOCK_CNT_W-1:0]    blk_cnt;
   logic [LINE_W-1:0]         line_cnt;
   logic [NUM_RS_UNITS_W-1:0] unit_sel;
   logic                      in_rdy;
   logic                      hdr_val;
   logic                      drain;

   logic last_line, last_block, fire;

   assign last_line  = (line_cnt == LINE_W'(PARITY_LINES - 1));
   assign last_block = (blk_cnt == num_blocks - BLOCK_CNT_W'(1));

   // Parity path is a pure mux onto the selected unit; no buffering.
   assign stream_encoder_dst_data_val  = drain & rs_unit_out_ctrl_val[unit_sel];
   assign stream_encoder_dst_data      = rs_unit_out_ctrl_data[int'(unit_sel)*DATA_W +: DATA_W];
   assign stream_encoder_dst_data_last = drain & last_line & last_block;
   assign fire = stream_encoder_dst_data_val & dst_stream_encoder_data_rdy;

   always_comb begin
      out_ctrl_rs_unit_rdy           = '0;
      out_ctrl_rs_unit_rdy[unit_sel] = drain & dst_stream_encoder_data_rdy;
   end

   assign out_ctrl_in_ctrl_rdy              = in_rdy;
   assign stream_encoder_dst_hdr_val        = hdr_val;
   assign stream_encoder_dst_hdr_num_blocks = num_blocks;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         num_blocks <= '0;
         blk_cnt    <= '0;
         line_cnt   <= '0;
         unit_sel   <= '0;
         in_rdy     <= 1'b1;
         hdr_val    <= 1'b0;
         drain      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_ctrl_out_ctrl_val) begin
               num_blocks <= in_ctrl_out_ctrl_num_blocks;
               blk_cnt    <= '0;
               line_cnt   <= '0;
               unit_sel   <= '0;
               in_rdy     <= 1'b0;
               hdr_val    <= 1'b1;
               state      <= HDR_OUT;
            end
            HDR_OUT: if (dst_stream_encoder_hdr_rdy) begin
               hdr_val <= 1'b0;
               if (num_blocks == '0) begin
                  in_rdy <= 1'b1;
                  state  <= IDLE;
               end else begin
                  drain <= 1'b1;
                  state <= DRAIN_BLOCK;
               end
            end
            DRAIN_BLOCK: if (fire) begin
               if (last_line) begin
                  line_cnt <= '0;
                  blk_cnt  <= blk_cnt + BLOCK_CNT_W'(1);
                  unit_sel <= (unit_sel == NUM_RS_UNITS_W'(NUM_RS_UNITS - 1)) ? '0
                              : unit_sel + NUM_RS_UNITS_W'(1);
                  if (last_block) begin
                     drain  <= 1'b0;
                     in_rdy <= 1'b1;
                     state  <= IDLE;
                  end
               end else begin
                  line_cnt <= line_cnt + LINE_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               in_rdy  <= 1'b1;
               hdr_val <= 1'b0;
               drain   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// Directed bench for rs_encode_stream_out_ctrl: 4 units, 2 parity lines per block.
module tb_rs_encode_stream_out_ctrl;

   localparam int NU = 4;
   localparam int DW = 256;
   localparam int PL = 2;
   localparam int BW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_val = 1'b0;
   logic [BW-1:0]   in_num = '0;
   logic            in_rdy;
   logic [NU-1:0]   u_val = '1;
   logic [NU*DW-1:0] u_data;
   logic [NU-1:0]   u_rdy;
   logic            hdr_val;
   logic [BW-1:0]   hdr_num;
   logic            hdr_rdy = 1'b0;
   logic            d_val;
   logic [DW-1:0]   d_data;
   logic            d_last;
   logic            d_rdy = 1'b0;

   int checks = 0;
   int failures = 0;

   // Each unit produces a numbered sequence of parity lines, advanced on its handshake.
   logic [23:0] seq [NU];
   int exp_seq [NU];

   function automatic logic [DW-1:0] pat(input int u, input int s);
      logic [31:0] w;
      w = {u[7:0], s[23:0]};
      return {8{w}};
   endfunction

   always #5 clk = ~clk;

   initial for (int i = 0; i < NU; i++) seq[i] = '0;
   always @(posedge clk)
      for (int i = 0; i < NU; i++)
         if (u_val[i] && u_rdy[i]) seq[i] <= seq[i] + 24'd1;

   for (genvar g = 0; g < NU; g++) begin : g_unit
      assign u_data[g*DW +: DW] = pat(g, int'(seq[g]));
   end

   rs_encode_stream_out_ctrl #(
      .NUM_RS_UNITS(NU), .DATA_W(DW), .PARITY_LINES(PL), .BLOCK_CNT_W(BW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_ctrl_out_ctrl_val(in_val), .in_ctrl_out_ctrl_num_blocks(in_num),
      .out_ctrl_in_ctrl_rdy(in_rdy),
      .rs_unit_out_ctrl_val(u_val), .rs_unit_out_ctrl_data(u_data),
      .out_ctrl_rs_unit_rdy(u_rdy),
      .stream_encoder_dst_hdr_val(hdr_val), .stream_encoder_dst_hdr_num_blocks(hdr_num),
      .dst_stream_encoder_hdr_rdy(hdr_rdy),
      .stream_encoder_dst_data_val(d_val), .stream_encoder_dst_data(d_data),
      .stream_encoder_dst_data_last(d_last),
      .dst_stream_encoder_data_rdy(d_rdy)
   );

   // One full request: accept, header (optionally stalled), drain all lines.
   // mode 0: sink and units always ready; 1: sink ready toggles; 2: also unit 1 stalls 4 cycles.
   task automatic drain_request(input int n, input int hdr_wait, input int mode);
      int j, cyc, u1_hold, eu, exp_lines;
      logic [NU-1:0] exp_rdy;
      exp_lines = n * PL;
      @(negedge clk);
      in_val = 1'b1; in_num = BW'(n); hdr_rdy = 1'b0; d_rdy = 1'b1; u_val = '1;
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin failures++; $display("FAIL accept_rdy n=%0d got=%b exp=1", n, in_rdy); end
      @(posedge clk);
      for (int k = 0; k < hdr_wait; k++) begin
         @(negedge clk);
         in_val = 1'b0; hdr_rdy = 1'b0;
         #1;
         checks++;
         if (hdr_val !== 1'b1 || hdr_num !== BW'(n) || u_rdy !== '0 || d_val !== 1'b0 || in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL hdr_hold k=%0d hdr_val=%b num=%0d u_rdy=%b d_val=%b in_rdy=%b exp 1/%0d/0000/0/0",
                     k, hdr_val, hdr_num, u_rdy, d_val, in_rdy, n);
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_val = 1'b0; hdr_rdy = 1'b1;
      #1;
      checks++;
      if (hdr_val !== 1'b1 || hdr_num !== BW'(n) || d_val !== 1'b0 || u_rdy !== '0 || in_rdy !== 1'b0) begin
         failures++;
         $display("FAIL hdr n=%0d hdr_val=%b num=%0d d_val=%b u_rdy=%b in_rdy=%b", n, hdr_val, hdr_num, d_val, u_rdy, in_rdy);
      end
      @(posedge clk);
      j = 0; cyc = 0; u1_hold = 0;
      while (j < exp_lines && cyc < 200) begin
         @(negedge clk);
         hdr_rdy = 1'b0;
         eu = (j / PL) % NU;
         d_rdy = (mode == 0) ? 1'b1 : cyc[0];
         u_val = '1;
         if (mode == 2 && eu == 1 && u1_hold < 4) begin
            u_val[1] = 1'b0;
            u1_hold++;
         end
         #1;
         exp_rdy = '0;
         exp_rdy[eu] = d_rdy;
         checks++;
         if (d_val !== u_val[eu] || u_rdy !== exp_rdy || hdr_val !== 1'b0 || in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL drain_ctl n=%0d line=%0d d_val=%b u_rdy=%b hdr_val=%b in_rdy=%b exp %b/%b/0/0",
                     n, j, d_val, u_rdy, hdr_val, in_rdy, u_val[eu], exp_rdy);
         end
         if (d_val === 1'b1) begin
            checks++;
            if (d_data !== pat(eu, exp_seq[eu]) || d_last !== (j == exp_lines - 1)) begin
               failures++;
               $display("FAIL drain_data n=%0d line=%0d data=%h last=%b exp=%h last=%b",
                        n, j, d_data[31:0], d_last, pat(eu, exp_seq[eu]) & 256'hffffffff, (j == exp_lines - 1));
            end
            if (d_rdy) begin
               exp_seq[eu]++;
               j++;
            end
         end
         cyc++;
         @(posedge clk);
      end
      checks++;
      if (j != exp_lines) begin failures++; $display("FAIL drain_timeout n=%0d lines=%0d exp=%0d", n, j, exp_lines); end
      @(negedge clk);
      d_rdy = 1'b1; u_val = '1;
      #1;
      checks++;
      if (in_rdy !== 1'b1 || d_val !== 1'b0 || hdr_val !== 1'b0 || u_rdy !== '0) begin
         failures++;
         $display("FAIL back_idle n=%0d in_rdy=%b d_val=%b hdr_val=%b u_rdy=%b exp 1/0/0/0", n, in_rdy, d_val, hdr_val, u_rdy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1 || hdr_val !== 1'b0 || d_val !== 1'b0 || d_last !== 1'b0 || u_rdy !== '0) begin
         failures++;
         $display("FAIL reset_state in_rdy=%b hdr_val=%b d_val=%b last=%b u_rdy=%b exp 1/0/0/0/0", in_rdy, hdr_val, d_val, d_last, u_rdy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1 || hdr_val !== 1'b0 || d_val !== 1'b0) begin
         failures++;
         $display("FAIL post_reset in_rdy=%b hdr_val=%b d_val=%b exp 1/0/0", in_rdy, hdr_val, d_val);
      end
   endtask

   task automatic test_basic();      drain_request(3, 0, 0); endtask
   task automatic test_round_robin(); drain_request(5, 0, 0); drain_request(2, 0, 0); endtask
   task automatic test_stall();      drain_request(3, 0, 2); endtask
   task automatic test_zero_blocks(); drain_request(0, 0, 0); endtask
   task automatic test_hdr_hold();   drain_request(2, 10, 1); endtask

   task automatic test_async_reset();
      int eu;
      @(negedge clk);
      in_val = 1'b1; in_num = BW'(3); hdr_rdy = 1'b1; d_rdy = 1'b1; u_val = '1;
      @(negedge clk);
      in_val = 1'b0;
      @(negedge clk);
      hdr_rdy = 1'b0;
      for (int j = 0; j < 5; j++) begin
         eu = (j / PL) % NU;
         #1;
         checks++;
         if (d_val !== 1'b1 || d_data !== pat(eu, exp_seq[eu])) begin
            failures++;
            $display("FAIL arst_pre line=%0d d_val=%b data=%h", j, d_val, d_data[31:0]);
         end
         exp_seq[eu]++;
         @(negedge clk);
      end
      // Line 5 (second line of block 2) is presented; pull reset between clock edges.
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (d_val !== 1'b0 || d_last !== 1'b0 || u_rdy !== '0 || hdr_val !== 1'b0 || in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL arst_clear d_val=%b last=%b u_rdy=%b hdr_val=%b in_rdy=%b exp 0/0/0/0/1", d_val, d_last, u_rdy, hdr_val, in_rdy);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drain_request(1, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < NU; i++) exp_seq[i] = 0;
      test_reset();
      test_basic();
      test_round_robin();
      test_stall();
      test_zero_blocks();
      test_hdr_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
